// File: rtl/zarb_pkg.sv
// Shared types for the zmem_arbiter memory-port arbiter: owner codes, FSM states
// and the bit positions of the one-hot grant vector.
package zarb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2,
    OWN_VID  = 2'd3
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Grant vector layout; normal priority runs from the highest index down.
  localparam int unsigned GNT_DMA = 0;
  localparam int unsigned GNT_CPU = 1;
  localparam int unsigned GNT_VID = 2;
  localparam int unsigned NREQ    = 3;

endpackage

// File: rtl/zarb_pick.sv
// Combinational priority pick: vid > cpu > dma, or cpu first when starve_i is set.
// Zero latency; the caller gates candidates so no grant is issued while busy.
module zarb_pick
  import zarb_pkg::*;
(
  input  logic            vid_i,
  input  logic            cpu_i,
  input  logic            dma_i,
  input  logic            starve_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [1:0]      owner_o
);

  always_comb begin
    gnt_o   = '0;
    owner_o = OWN_NONE;
    if (starve_i && cpu_i) begin
      gnt_o[GNT_CPU] = 1'b1;
      owner_o        = OWN_CPU;
    end else if (vid_i) begin
      gnt_o[GNT_VID] = 1'b1;
      owner_o        = OWN_VID;
    end else if (cpu_i) begin
      gnt_o[GNT_CPU] = 1'b1;
      owner_o        = OWN_CPU;
    end else if (dma_i) begin
      gnt_o[GNT_DMA] = 1'b1;
      owner_o        = OWN_DMA;
    end
  end

endmodule

// File: rtl/zmem_arbiter.sv
// Shares one memory port between Z80 CPU, DMA and video; one transaction in flight,
// grant->mem_req 1 cycle, mem_ack->done/ack 1 cycle. ZARB_STARVE_EN adds CPU anti-starvation.
module zmem_arbiter
  import zarb_pkg::*;
#(
  parameter int AW         = 22,
  parameter int DW         = 16,
  parameter int STARVE_LIM = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_rdata,
  output logic          vid_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  if (STARVE_LIM < 1) begin : g_lim_chk
    $error("zmem_arbiter: STARVE_LIM must be at least 1");
  end

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic            cpu_pend_q, cpu_pend_d;
  logic            cpu_we_q, cpu_we_d;
  logic [AW-1:0]   cpu_addr_q, cpu_addr_d;
  logic [DW-1:0]   cpu_wdata_q, cpu_wdata_d;
  logic            cpu_stall_q, cpu_stall_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   dma_rdata_q, dma_rdata_d;
  logic [DW-1:0]   vid_rdata_q, vid_rdata_d;
  logic            cpu_done_q, cpu_done_d;
  logic            dma_ack_q, dma_ack_d;
  logic            vid_ack_q, vid_ack_d;

  logic            idle, cpu_acc, cpu_cand, cand_we, starve;
  logic [AW-1:0]   cand_addr;
  logic [DW-1:0]   cand_wdata;
  logic [NREQ-1:0] gnt;
  logic [1:0]      pick_owner;

  assign idle     = (state_q == ST_IDLE);
  // The pending flag stays set through the CPU's own access, which blocks re-capture.
  assign cpu_acc  = cpu_req && !cpu_pend_q;
  assign cpu_cand = cpu_pend_q || cpu_req;
  assign cand_we    = cpu_pend_q ? cpu_we_q    : cpu_we;
  assign cand_addr  = cpu_pend_q ? cpu_addr_q  : cpu_addr;
  assign cand_wdata = cpu_pend_q ? cpu_wdata_q : cpu_wdata;

  zarb_pick u_pick (
    .vid_i    (idle && vid_req),
    .cpu_i    (idle && cpu_cand),
    .dma_i    (idle && dma_req),
    .starve_i (starve),
    .gnt_o    (gnt),
    .owner_o  (pick_owner)
  );

`ifdef ZARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIM + 1);
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  assign starve = (starve_cnt_q == CW'(STARVE_LIM));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (gnt[GNT_CPU]) begin
      starve_cnt_d = '0;
    end else if (idle && cpu_pend_q && !starve) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cpu_pend_d  = cpu_pend_q;
    cpu_we_d    = cpu_we_q;
    cpu_addr_d  = cpu_addr_q;
    cpu_wdata_d = cpu_wdata_q;
    cpu_stall_d = cpu_stall_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    vid_rdata_d = vid_rdata_q;
    cpu_done_d  = 1'b0;
    dma_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;

    if (cpu_acc) begin
      cpu_pend_d  = 1'b1;
      cpu_we_d    = cpu_we;
      cpu_addr_d  = cpu_addr;
      cpu_wdata_d = cpu_wdata;
      cpu_stall_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          state_d   = ST_BUSY;
          owner_d   = owner_e'(pick_owner);
          mem_req_d = 1'b1;
          if (gnt[GNT_CPU]) begin
            mem_we_d    = cand_we;
            mem_addr_d  = cand_addr;
            mem_wdata_d = cand_wdata;
          end else if (gnt[GNT_DMA]) begin
            mem_we_d    = dma_we;
            mem_addr_d  = dma_addr;
            mem_wdata_d = dma_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = vid_addr;
            mem_wdata_d = '0;
          end
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          owner_d   = OWN_NONE;
          mem_req_d = 1'b0;
          case (owner_q)
            OWN_CPU: begin
              cpu_rdata_d = mem_rdata;
              cpu_done_d  = 1'b1;
              cpu_pend_d  = 1'b0;
              cpu_stall_d = 1'b0;
            end
            OWN_DMA: begin
              dma_rdata_d = mem_rdata;
              dma_ack_d   = 1'b1;
            end
            OWN_VID: begin
              vid_rdata_d = mem_rdata;
              vid_ack_d   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      cpu_pend_q  <= 1'b0;
      cpu_we_q    <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= '0;
      cpu_stall_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      vid_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      dma_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cpu_pend_q  <= cpu_pend_d;
      cpu_we_q    <= cpu_we_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_wdata_q <= cpu_wdata_d;
      cpu_stall_q <= cpu_stall_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      cpu_done_q  <= cpu_done_d;
      dma_ack_q   <= dma_ack_d;
      vid_ack_q   <= vid_ack_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_stall = cpu_stall_q;
  assign dma_rdata = dma_rdata_q;
  assign dma_ack   = dma_ack_q;
  assign vid_rdata = vid_rdata_q;
  assign vid_ack   = vid_ack_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_zmem_arbiter.sv
// Scoreboard bench for zmem_arbiter: expected grants are queued as requests are driven
// and matched when mem_req rises; a 4-cycle memory model returns addr-derived data.
`timescale 1ns/1ps
module tb_zmem_arbiter;
  import zarb_pkg::*;

  localparam int AW = 22;
  localparam int DW = 16;
  localparam logic [AW-1:0] VID_A = 22'h2A000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req, cpu_we, cpu_done, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_ack;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          vid_req, vid_ack;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  zmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [1:0]    own;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t exp_q[$];

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hBFCC;
  endfunction

  // Memory model: acks on the 4th cycle mem_req is seen high.
  int req_age = 0;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (rst || !mem_req) begin
        req_age = 0;
      end else begin
        req_age++;
        if (req_age == 4) begin
          mem_ack   = 1'b1;
          mem_rdata = rd_fn(mem_addr);
          req_age   = 0;
        end
      end
    end
  end

  // Level requesters drop their request in the cycle the ack pulse is seen.
  bit vid_hold = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (vid_ack && !vid_hold) vid_req = 1'b0;
      if (dma_ack) dma_req = 1'b0;
    end
  end

  logic [1:0]    cur_own = OWN_NONE;
  logic [AW-1:0] gnt_addr = '0;
  logic [AW-1:0] ack_addr = '0;
  bit            prev_req = 1'b0;
  bit            vid_stream = 1'b0;
  int            vid_grants = 0;
  int            vid_at_cpu = 0;
  int            n_cpu = 0, n_dma = 0, n_vid = 0;
  int            rise_cyc = 0, dma_ack_cyc = 0;

  initial begin : monitor
    txn_t e;
    int   nacks;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_req && !prev_req) begin
          rise_cyc = cyc;
          gnt_addr = mem_addr;
          if (vid_stream && mem_addr == VID_A) begin
            cur_own = OWN_VID;
            vid_grants++;
          end else if (exp_q.size() == 0) begin
            check("sb_grant_expected", exp_q.size(), 1);
            cur_own = OWN_NONE;
          end else begin
            e = exp_q.pop_front();
            cur_own = e.own;
            if (e.own == OWN_CPU) vid_at_cpu = vid_grants;
            check("sb_mem_addr", mem_addr, e.addr);
            check("sb_mem_we", mem_we, e.we);
            if (e.we) check("sb_mem_wdata", mem_wdata, e.wdata);
          end
        end
        if (mem_req && mem_ack) begin
          ack_addr = mem_addr;
          check("addr_stable", mem_addr, gnt_addr);
        end
        nacks = int'(cpu_done) + int'(dma_ack) + int'(vid_ack);
        if (nacks != 0) begin
          check("ack_onehot", nacks, 1);
          if (cpu_done) begin
            n_cpu++;
            check("cpu_done_owner", cur_own, OWN_CPU);
            check("cpu_rdata", cpu_rdata, rd_fn(ack_addr));
          end
          if (dma_ack) begin
            n_dma++;
            dma_ack_cyc = cyc;
            check("dma_ack_owner", cur_own, OWN_DMA);
            check("dma_rdata", dma_rdata, rd_fn(ack_addr));
          end
          if (vid_ack) begin
            n_vid++;
            check("vid_ack_owner", cur_own, OWN_VID);
            check("vid_rdata", vid_rdata, rd_fn(ack_addr));
          end
        end
      end
      prev_req = mem_req;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [1:0] own, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    txn_t t;
    t.own = own; t.we = we; t.addr = a; t.wdata = d;
    exp_q.push_back(t);
  endtask

  task automatic cpu_strobe(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    tick();
    cpu_req = 1'b0;
  endtask

  function automatic int cnt_of(input int w);
    case (w)
      0:       return n_cpu;
      1:       return n_dma;
      default: return n_vid;
    endcase
  endfunction

  task automatic wait_n(input string tag, input int w, input int target, input int budget);
    int b = budget;
    while (cnt_of(w) < target && b > 0) begin
      tick();
      b--;
    end
    check(tag, cnt_of(w) >= target, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int b_cpu, b_dma, b_vid, b, d_cyc, g0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    vid_req = 0; vid_addr = '0;

    repeat (2) tick();
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    check("rst_acks", {cpu_done, dma_ack, vid_ack}, 0);
    check("rst_rdata", {cpu_rdata, dma_rdata}, 0);
    check("rst_mem_fields", {mem_we, mem_addr}, 0);
    tick();
    rst = 1'b0;

    // CPU read from an idle arbiter, strobe at cycle 10.
    while (cyc < 10) tick();
    push(OWN_CPU, 1'b0, 22'h00123, 16'h0);
    cpu_strobe(1'b0, 22'h00123, 16'h0);
    for (int c = 11; c <= 15; c++) begin
      @(negedge clk);
      check($sformatf("t1_mem_req_c%0d", c), mem_req, c <= 14);
      check($sformatf("t1_stall_c%0d", c), cpu_stall, c <= 14);
      check($sformatf("t1_done_c%0d", c), cpu_done, c == 15);
      if (c == 14) check("t1_mem_addr", mem_addr, 22'h00123);
      if (c == 15) check("t1_rdata", cpu_rdata, 16'hBEEF);
    end

    // Three-way collision: video, then CPU, then DMA.
    tick(); tick();
    b_cpu = n_cpu; b_dma = n_dma; b_vid = n_vid;
    push(OWN_VID, 1'b0, VID_A, 16'h0);
    push(OWN_CPU, 1'b0, 22'h01000, 16'h0);
    push(OWN_DMA, 1'b0, 22'h30000, 16'h0);
    vid_req = 1'b1; vid_addr = VID_A;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 22'h30000; dma_wdata = 16'h1111;
    cpu_strobe(1'b0, 22'h01000, 16'h0);
    wait_n("t2_vid_ack", 2, b_vid + 1, 60);
    wait_n("t2_cpu_done", 0, b_cpu + 1, 60);
    wait_n("t2_dma_ack", 1, b_dma + 1, 60);
    repeat (8) tick();
    check("t2_vid_count", n_vid - b_vid, 1);
    check("t2_cpu_count", n_cpu - b_cpu, 1);
    check("t2_dma_count", n_dma - b_dma, 1);
    check("t2_sb_drained", exp_q.size(), 0);

    // CPU write captured while DMA is busy; a second strobe is dropped.
    b_cpu = n_cpu; b_dma = n_dma;
    push(OWN_DMA, 1'b1, 22'h30010, 16'h5A5A);
    push(OWN_CPU, 1'b1, 22'h00200, 16'h00A5);
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 22'h30010; dma_wdata = 16'h5A5A;
    tick();
    cpu_strobe(1'b1, 22'h00200, 16'h00A5);
    @(negedge clk);
    check("t3_stall_pending", cpu_stall, 1);
    tick();
    cpu_strobe(1'b1, 22'h00300, 16'h0FFF);
    wait_n("t3_dma_ack", 1, b_dma + 1, 60);
    wait_n("t3_cpu_done", 0, b_cpu + 1, 60);
    check("t3_cpu_issue_cycle", rise_cyc, dma_ack_cyc + 1);
    repeat (12) tick();
    check("t3_cpu_count", n_cpu - b_cpu, 1);
    check("t3_sb_drained", exp_q.size(), 0);

    // Reset in the middle of a CPU access.
    b_cpu = n_cpu; b_dma = n_dma; b_vid = n_vid;
    push(OWN_CPU, 1'b0, 22'h00400, 16'h0);
    cpu_strobe(1'b0, 22'h00400, 16'h0);
    tick();
    check("t4_req_before_rst", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("t4_mem_req_async", mem_req, 0);
    check("t4_stall_cleared", cpu_stall, 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (8) tick();
    check("t4_no_pulses", (n_cpu - b_cpu) + (n_dma - b_dma) + (n_vid - b_vid), 0);
    push(OWN_CPU, 1'b0, 22'h00404, 16'h0);
    cpu_strobe(1'b0, 22'h00404, 16'h0);
    wait_n("t4_fresh_done", 0, b_cpu + 1, 40);

    // Back-to-back: new strobe in the cpu_done cycle.
    tick();
    b_cpu = n_cpu;
    push(OWN_CPU, 1'b0, 22'h00500, 16'h0);
    cpu_strobe(1'b0, 22'h00500, 16'h0);
    b = 40;
    while (!cpu_done && b > 0) begin
      tick();
      b--;
    end
    check("t5_first_done", cpu_done, 1);
    check("t5_stall_low_at_done", cpu_stall, 0);
    d_cyc = cyc;
    push(OWN_CPU, 1'b0, 22'h00600, 16'h0);
    cpu_strobe(1'b0, 22'h00600, 16'h0);
    @(negedge clk);
    check("t5_stall_reasserted", cpu_stall, 1);
    wait_n("t5_second_done", 0, b_cpu + 2, 40);
    check("t5_b2b_issue_cycle", rise_cyc, d_cyc + 1);

    // Continuous video stream against one CPU strobe.
    tick();
    b_cpu = n_cpu;
    vid_stream = 1'b1; vid_hold = 1'b1;
    vid_addr = VID_A; vid_req = 1'b1;
    b = 20;
    while (!mem_req && b > 0) begin
      tick();
      b--;
    end
    tick();
    g0 = vid_grants;
    push(OWN_CPU, 1'b0, 22'h00700, 16'h0);
    cpu_strobe(1'b0, 22'h00700, 16'h0);
    b = 400;
    while (n_cpu == b_cpu && b > 0) begin
      tick();
      b--;
`ifndef ZARB_STARVE_EN
      if (vid_hold && (vid_grants - g0) >= 12) vid_hold = 1'b0;
`endif
    end
    check("t6_cpu_done", n_cpu - b_cpu, 1);
`ifdef ZARB_STARVE_EN
    check("t6_vid_grants_before_cpu", vid_at_cpu - g0, 8);
`else
    check("t6_vid_grants_before_cpu", vid_at_cpu - g0, 12);
`endif
    vid_hold = 1'b0;
    b = 40;
    while (vid_req && b > 0) begin
      tick();
      b--;
    end
    check("t6_vid_released", vid_req, 0);
    repeat (8) tick();
    vid_stream = 1'b0;
    check("t6_sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
